hash_msg_padder: RTL and testbench
==================================

# hash_msg_padder

Upstream message-fetch and padding stage for the super hash processor. Reads a byte-sized message from the shared 32-bit word memory and byte-swaps each word. Appends the 0x80 pad byte, zero fill and 64-bit bit-length. Streams the result as 16-word 512-bit blocks, one 32-bit word per handshake, to the MD5/SHA1/SHA256 round engine. Padding is identical for all three algorithms, so the block is opcode-agnostic.

## Interface
- ADDR_W, 16, memory word-address width
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  begin a message; sampled only when busy=0
- message_addr  in  32  word address of first message word; low ADDR_W bits used
- size  in  32  message length in bytes, 0 to 2^32-1
- mem_re  out  1  read request; address presented this cycle
- mem_addr  out  ADDR_W  read word address
- mem_read_data  in  32  read data, valid exactly one cycle after mem_re
- w_valid  out  1  w_data valid
- w_ready  in  1  consumer accepts when w_valid & w_ready
- w_data  out  32  padded, byte-swapped message word
- w_index  out  4  word index within the block, 0..15
- w_last_block  out  1  current word belongs to the final block
- busy  out  1  message in progress
- done  out  1  one-cycle pulse after the final word (index 15 of the last block) is accepted

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE + start: latch message_addr and size; nblk = (size+8)/64 + 1 (27-bit); total words N = 16·nblk; k = 0; go to RUN; busy=1.
- Word k content. Define q=size/4 and r=size%4. Define swap(x)={x[7:0],x[15:8],x[23:16],x[31:24]}.
  - k<q: swap(mem[addr+k]).
  - k==q, r=0: 32'h80000000.
  - k==q, r=1: swap(mem)&FF000000 | 00800000.
  - k==q, r=2: swap(mem)&FFFF0000 | 00008000.
  - k==q, r=3: swap(mem)&FFFFFF00 | 00000080.
  - k==N-2: size>>29.
  - k==N-1: size<<3, truncated to 32 bits.
  - Otherwise: 0.
- Memory is read only for k ≤ q with k<q, or k==q with r≠0. No reads for pure pad or length words.
- Generator issues one word per cycle into a 2-entry FIFO. Issue is allowed when FIFO occupancy plus in-flight reads is < 2.
- The issue stage records the read/merge kind. The merge is applied when mem_read_data returns, one cycle later.
- FIFO head drives w_data, w_index and w_last_block.
- RUN→FLUSH when all N words have been issued. FLUSH→IDLE when the FIFO is empty and the last word has been accepted. done=1 for that cycle; busy=0 from the next cycle.
- start while busy=1 is ignored.
- mem_addr = (message_addr + k) mod 2^ADDR_W. Wrap-around is permitted.

## Timing
- Reset values: busy=0, done=0, mem_re=0, mem_addr=0, w_valid=0, w_data=0, w_index=0, w_last_block=0. FIFO and counters are cleared.
- Reset mid-message aborts it immediately. No done pulse is produced.
- Sustained w_ready=1: first w_valid at cycle start+3; thereafter one word per cycle; done 1 cycle after the final accept.
- Under w_ready=0, w_valid and w_data hold stable. There are never more than 2 outstanding words, and no data is lost or duplicated.
- The same-cycle pop and push on a full FIFO is legal, and occupancy is unchanged.

## Structure
- Package hash_pkg: PAD_BYTE, BLOCK_WORDS=16, byte_swap function, word-kind enum (MSG, PARTIAL, PAD80, ZERO, LEN_HI, LEN_LO).
- One sub-module: hash_word_fifo (depth 2, width 32+4+1, with count output).

## Test plan
- size=0 → 1 block: 80000000, 14×00000000, 00000000, 00000000; no mem_re; done after 16 accepts.
- size=505 at 1000, mem[1000]=01234567, each subsequent word rotl1 → 9 blocks (144 words). Word 0 = 67452301. Word 126 = swap(mem[1126])&FF000000|00800000. Word 142 = 0. Word 143 = 00000FC8.
- size=55 → 1 block, word 13 = swap(mem)&FFFFFF00|80, word 15 = 000001B8. size=56 → 2 blocks, word 14 = 80000000, word 31 = 000001C0.
- Random w_ready toggling on size=505 → word stream identical to the stalled-free run; at most 2 outstanding; w_data stable while stalled.
- reset_n low at word 20 of size=505 → all outputs go to reset values next cycle, no done. A subsequent start produces a correct full stream.
- start asserted again while busy → ignored, first message completes unchanged.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types and helpers for the message padding stage of the hash processor.
// Word kinds classify each generated word so the memory merge can be applied one cycle late.
package hash_pkg;

    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned FIFO_W      = 32 + 4 + 1;

    typedef enum logic [2:0] {
        MSG,
        PARTIAL,
        PAD80,
        ZERO,
        LEN_HI,
        LEN_LO
    } word_kind_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } pad_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  index;
        logic        last_block;
    } pad_word_t;

    function automatic logic [31:0] byte_swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Keep the r valid message bytes of the final partial word and place the pad byte after them.
    function automatic logic [31:0] merge_partial(input logic [31:0] sw, input logic [1:0] r);
        logic [31:0] res;
        case (r)
            2'd1:    res = (sw & 32'hFF00_0000) | {8'h00, PAD_BYTE, 16'h0000};
            2'd2:    res = (sw & 32'hFFFF_0000) | {16'h0000, PAD_BYTE, 8'h00};
            2'd3:    res = (sw & 32'hFFFF_FF00) | {24'h00_0000, PAD_BYTE};
            default: res = {PAD_BYTE, 24'h00_0000};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hash_msg_padder_if.sv
// Memory read port and padded-word stream of the message padder.
// master = padder side, slave = memory / round-engine side.
interface hash_msg_padder_if #(
    parameter int unsigned ADDR_W = 16
) ();

    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_read_data;

    logic              w_valid;
    logic              w_ready;
    logic [31:0]       w_data;
    logic [3:0]        w_index;
    logic              w_last_block;

    modport master (
        output mem_re, mem_addr, w_valid, w_data, w_index, w_last_block,
        input  mem_read_data, w_ready
    );

    modport slave (
        input  mem_re, mem_addr, w_valid, w_data, w_index, w_last_block,
        output mem_read_data, w_ready
    );

endinterface

// File: rtl/hash_word_fifo.sv
// Two-entry word FIFO between the padder issue stage and the round engine.
// Simultaneous push and pop on a full FIFO keeps occupancy unchanged.
module hash_word_fifo #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/hash_msg_padder.sv
// Message fetch and padding stage: reads byte-swapped message words, appends 0x80, zero fill
// and the 64-bit bit length, and streams 16-word blocks to the round engine.
module hash_msg_padder
    import hash_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [31:0]         message_addr,
    input  logic [31:0]         size,
    output logic                busy,
    output logic                done,
    hash_msg_padder_if.master   bus
);

    pad_state_e        state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [31:0]       size_q;
    logic [30:0]       nwords_q;
    logic [30:0]       k_q;
    logic              acc_last_q;

    logic              pend_valid_q;
    word_kind_e        pend_kind_q;
    logic [31:0]       pend_data_q;
    logic [3:0]        pend_index_q;
    logic              pend_last_q;

    logic [32:0]       size_plus8;
    logic [26:0]       nblk;
    logic [30:0]       q_words;
    word_kind_e        kind;
    logic [31:0]       const_data;
    logic              issue;
    logic              pop;
    logic              final_accept;
    logic [2:0]        inflight_sum;
    logic [2:0]        inflight_cap;

    pad_word_t         push_word;
    pad_word_t         head_word;
    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_valid;
    logic [1:0]        fifo_count;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^message_addr[31:ADDR_W];

    assign size_plus8 = {1'b0, size} + 33'd8;
    assign nblk       = size_plus8[32:6] + 27'd1;
    assign q_words    = {1'b0, size_q[31:2]};

    always_comb begin
        kind = ZERO;
        if (k_q == nwords_q - 31'd1) begin
            kind = LEN_LO;
        end else if (k_q == nwords_q - 31'd2) begin
            kind = LEN_HI;
        end else if (k_q < q_words) begin
            kind = MSG;
        end else if (k_q == q_words) begin
            kind = (size_q[1:0] == 2'd0) ? PAD80 : PARTIAL;
        end
    end

    always_comb begin
        case (kind)
            PAD80:   const_data = {PAD_BYTE, 24'h00_0000};
            LEN_HI:  const_data = {29'd0, size_q[31:29]};
            LEN_LO:  const_data = {size_q[28:0], 3'b000};
            default: const_data = '0;
        endcase
    end

    assign head_word = pad_word_t'(fifo_head);
    assign pop       = fifo_valid && bus.w_ready;
    assign final_accept = pop && head_word.last_block && (head_word.index == 4'hF);

    // A pop this cycle frees a slot, so issue keeps one word per cycle under sustained ready.
    assign inflight_sum = {1'b0, fifo_count} + {2'b00, pend_valid_q};
    assign inflight_cap = 3'd2 + {2'b00, pop};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issue && (k_q == nwords_q - 31'd1)) state_d = FLUSH;
            FLUSH:   if (acc_last_q && !fifo_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == FLUSH) && acc_last_q && !fifo_valid;
        issue       = (state_q == RUN) && (inflight_sum < inflight_cap);
        bus.mem_re  = issue && ((kind == MSG) || (kind == PARTIAL));
    end

    assign bus.mem_addr = base_q + k_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q       <= '0;
            size_q       <= '0;
            nwords_q     <= '0;
            k_q          <= '0;
            acc_last_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_kind_q  <= ZERO;
            pend_data_q  <= '0;
            pend_index_q <= '0;
            pend_last_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                base_q   <= message_addr[ADDR_W-1:0];
                size_q   <= size;
                nwords_q <= {nblk, 4'b0000};
                k_q      <= '0;
            end else if (issue) begin
                k_q <= k_q + 31'd1;
            end

            if (state_q == IDLE) begin
                acc_last_q <= 1'b0;
            end else if (final_accept) begin
                acc_last_q <= 1'b1;
            end

            pend_valid_q <= issue;
            if (issue) begin
                pend_kind_q  <= kind;
                pend_data_q  <= const_data;
                pend_index_q <= k_q[3:0];
                pend_last_q  <= (k_q >= nwords_q - 31'd16);
            end
        end
    end

    always_comb begin
        push_word.index      = pend_index_q;
        push_word.last_block = pend_last_q;
        case (pend_kind_q)
            MSG:     push_word.data = byte_swap(bus.mem_read_data);
            PARTIAL: push_word.data = merge_partial(byte_swap(bus.mem_read_data), size_q[1:0]);
            default: push_word.data = pend_data_q;
        endcase
    end

    hash_word_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (pend_valid_q),
        .push_data_i (push_word),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign bus.w_valid      = fifo_valid;
    assign bus.w_data       = head_word.data;
    assign bus.w_index      = head_word.index;
    assign bus.w_last_block = head_word.last_block;

endmodule

// File: tb/tb_hash_msg_padder.sv
// Self-checking bench for hash_msg_padder: table of messages checked against a scoreboard
// built from a padding model, plus reset-abort and start-while-busy sequences.
module tb_hash_msg_padder;

    localparam int unsigned ADDR_W = 16;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  index;
        logic        last;
    } exp_word_t;

    typedef struct {
        logic [31:0] sz;
        logic [31:0] addr;
        bit          rnd;
        int unsigned words;
        int unsigned reads;
        int unsigned spot_k;
        logic [31:0] spot_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] message_addr = '0;
    logic [31:0] msg_size = '0;
    logic        busy;
    logic        done;

    hash_msg_padder_if #(.ADDR_W(ADDR_W)) bus ();

    hash_msg_padder #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .message_addr (message_addr),
        .size         (msg_size),
        .busy         (busy),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_re_cnt = 0;
    bit          rand_mode = 1'b0;
    exp_word_t   exp_q[$];
    logic [31:0] captured [256];
    int          acc_cnt, done_cnt, done_cyc, last_acc_cyc, first_valid_cyc, start_cyc, reads0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    vec_t        vecs [14];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        logic [63:0]       dbl;
        off = a - ADDR_W'(1000);
        dbl = {32'h0123_4567, 32'h0123_4567} << off[4:0];
        return dbl[63:32];
    endfunction

    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_read_data <= memword(bus.mem_addr);
            mem_re_cnt <= mem_re_cnt + 1;
        end
    end

    function automatic logic [31:0] swp(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] sz, input logic [31:0] base,
                                               input int unsigned k, input int unsigned n);
        int unsigned       q;
        logic [ADDR_W-1:0] a;
        logic [31:0]       m;
        q = sz >> 2;
        a = base[ADDR_W-1:0] + ADDR_W'(k);
        m = swp(memword(a));
        if (k == n - 1) return sz << 3;
        if (k == n - 2) return sz >> 29;
        if (k < q) return m;
        if (k == q) begin
            case (sz[1:0])
                2'd0: return 32'h8000_0000;
                2'd1: return (m & 32'hFF00_0000) | 32'h0080_0000;
                2'd2: return (m & 32'hFFFF_0000) | 32'h0000_8000;
                default: return (m & 32'hFFFF_FF00) | 32'h0000_0080;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // One cycle: move to negedge, drive w_ready for the coming edge, then observe the stream.
    task automatic step();
        exp_word_t e;
        @(negedge clk);
        #1;
        bus.w_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!reset_n) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("hold_valid", {31'd0, bus.w_valid}, 32'd1);
            check("hold_data", bus.w_data, prev_data);
        end
        if (bus.w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.w_valid && bus.w_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %h, required no further word", bus.w_data);
            end else begin
                e = exp_q.pop_front();
                check("w_data", bus.w_data, e.data);
                check("w_index", {28'd0, bus.w_index}, {28'd0, e.index});
                check("w_last_block", {31'd0, bus.w_last_block}, {31'd0, e.last});
            end
            if (acc_cnt < 256) captured[acc_cnt] = bus.w_data;
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = bus.w_valid && !bus.w_ready;
        prev_data  = bus.w_data;
    endtask

    task automatic launch(input logic [31:0] sz, input logic [31:0] adr, input bit rnd);
        longint      nl;
        int unsigned n;
        exp_word_t   e;
        nl = 16 * ((longint'(sz) + 8) / 64 + 1);
        n  = int'(nl);
        rand_mode = rnd;
        for (int unsigned k = 0; k < n; k++) begin
            e.data  = model_word(sz, adr, k, n);
            e.index = k[3:0];
            e.last  = (k >= n - 16);
            exp_q.push_back(e);
        end
        acc_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        reads0 = mem_re_cnt;
        start = 1'b1;
        message_addr = adr;
        msg_size = sz;
        start_cyc = cyc;
        step();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int unsigned words, input int unsigned reads);
        int unsigned t;
        t = 0;
        while (done_cnt == 0 && t < words * 8 + 50) begin
            step();
            t++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", t);
        end else begin
            check("accepted_words", acc_cnt, words);
            check("scoreboard_empty", exp_q.size(), 0);
            check("done_after_last", done_cyc - last_acc_cyc, 1);
            check("mem_reads", mem_re_cnt - reads0, reads);
            check("first_valid_latency", first_valid_cyc - start_cyc, 3);
            step();
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("idle_after_done", {31'd0, busy}, 32'd0);
            check("done_count", done_cnt, 1);
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_mem_re"}, {31'd0, bus.mem_re}, 32'd0);
        check({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
        check({tag, "_w_valid"}, {31'd0, bus.w_valid}, 32'd0);
        check({tag, "_w_data"}, bus.w_data, 32'd0);
        check({tag, "_w_index"}, {28'd0, bus.w_index}, 32'd0);
        check({tag, "_w_last_block"}, {31'd0, bus.w_last_block}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd0,   32'd1000,      1'b0, 16,  0,   0,   32'h8000_0000};
        vecs[1]  = '{32'd505, 32'd1000,      1'b0, 144, 127, 0,   32'h6745_2301};
        vecs[2]  = '{32'd505, 32'd1000,      1'b1, 144, 127, 126, 32'h5980_0000};
        vecs[3]  = '{32'd505, 32'd1000,      1'b0, 144, 127, 143, 32'h0000_0FC8};
        vecs[4]  = '{32'd55,  32'd1000,      1'b0, 16,  14,  13,  32'h24E0_AC80};
        vecs[5]  = '{32'd55,  32'd1000,      1'b1, 16,  14,  15,  32'h0000_01B8};
        vecs[6]  = '{32'd56,  32'd1000,      1'b0, 32,  14,  14,  32'h8000_0000};
        vecs[7]  = '{32'd56,  32'd1000,      1'b0, 32,  14,  31,  32'h0000_01C0};
        vecs[8]  = '{32'd1,   32'd1000,      1'b0, 16,  1,   0,   32'h6780_0000};
        vecs[9]  = '{32'd2,   32'd1000,      1'b1, 16,  1,   0,   32'h6745_8000};
        vecs[10] = '{32'd3,   32'd1000,      1'b0, 16,  1,   0,   32'h6745_2380};
        vecs[11] = '{32'd12,  32'h0001_FFFE, 1'b0, 16,  3,   2,   32'h4523_0167};
        vecs[12] = '{32'd119, 32'd1000,      1'b0, 32,  30,  31,  32'h0000_03B8};
        vecs[13] = '{32'd120, 32'd1000,      1'b1, 48,  30,  47,  32'h0000_03C0};

        bus.w_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].sz, vecs[i].addr, vecs[i].rnd);
            wait_done(vecs[i].words, vecs[i].reads);
            check($sformatf("spot_%0d_word%0d", i, vecs[i].spot_k),
                  captured[vecs[i].spot_k], vecs[i].spot_val);
        end

        // Reset in the middle of a 505-byte message, then a clean rerun.
        launch(32'd505, 32'd1000, 1'b0);
        for (int t = 0; t < 200 && acc_cnt < 20; t++) step();
        check("reached_word20", {31'd0, acc_cnt >= 20}, 32'd1);
        reset_n = 1'b0;
        step();
        check_reset_outputs("abort");
        exp_q.delete();
        reset_n = 1'b1;
        repeat (6) step();
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", {31'd0, busy}, 32'd0);
        launch(32'd505, 32'd1000, 1'b0);
        wait_done(144, 127);
        check("rerun_word126", captured[126], 32'h5980_0000);
        check("rerun_word142", captured[142], 32'h0000_0000);

        // A second start while busy must not disturb the running message.
        launch(32'd55, 32'd1000, 1'b0);
        step();
        start = 1'b1;
        message_addr = 32'd7;
        msg_size = 32'd505;
        step();
        start = 1'b0;
        wait_done(16, 14);
        check("busy_start_word13", captured[13], 32'h24E0_AC80);
        check("busy_start_word15", captured[15], 32'h0000_01B8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
